// File: rtl/vanilla_multicore_tx_arbiter_if.sv
// Bundle between the vanilla cores, the arbiter and the manycore endpoint.
// The arbiter connects through the slave modport; the environment uses master.
interface vanilla_multicore_tx_arbiter_if #(
    parameter int num_cores_p     = 4,
    parameter int payload_width_p = 32,
    parameter int data_width_p    = 32,
    parameter int reg_id_width_p  = 5,
    parameter int max_out_p       = 8
);
    localparam int CIW = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;
    localparam int LIW = reg_id_width_p - CIW;
    localparam int CW  = $clog2(max_out_p + 1);

    logic [num_cores_p-1:0]                 req_v_i;
    logic [num_cores_p*payload_width_p-1:0] req_payload_i;
    logic [num_cores_p*LIW-1:0]             req_reg_id_i;
    logic [num_cores_p-1:0]                 req_load_i;
    logic [num_cores_p-1:0]                 req_ready_o;
    logic                                   out_v_o;
    logic [payload_width_p-1:0]             out_payload_o;
    logic [reg_id_width_p-1:0]              out_reg_id_o;
    logic                                   out_credit_or_ready_i;
    logic                                   returned_v_i;
    logic [data_width_p-1:0]                returned_data_i;
    logic [reg_id_width_p-1:0]              returned_reg_id_i;
    logic                                   returned_yumi_o;
    logic [num_cores_p-1:0]                 resp_v_o;
    logic [data_width_p-1:0]                resp_data_o;
    logic [LIW-1:0]                         resp_reg_id_o;
    logic [num_cores_p-1:0]                 resp_yumi_i;
    logic [num_cores_p*CW-1:0]              outstanding_o;
    logic                                   err_o;

    modport slave (
        input  req_v_i, req_payload_i, req_reg_id_i, req_load_i,
        output req_ready_o,
        output out_v_o, out_payload_o, out_reg_id_o,
        input  out_credit_or_ready_i,
        input  returned_v_i, returned_data_i, returned_reg_id_i,
        output returned_yumi_o,
        output resp_v_o, resp_data_o, resp_reg_id_o,
        input  resp_yumi_i,
        output outstanding_o, err_o
    );

    modport master (
        output req_v_i, req_payload_i, req_reg_id_i, req_load_i,
        input  req_ready_o,
        input  out_v_o, out_payload_o, out_reg_id_o,
        output out_credit_or_ready_i,
        output returned_v_i, returned_data_i, returned_reg_id_i,
        input  returned_yumi_o,
        input  resp_v_o, resp_data_o, resp_reg_id_o,
        output resp_yumi_i,
        input  outstanding_o, err_o
    );
endinterface

// File: rtl/vanilla_multicore_tx_arbiter.sv
// Round-robin sharing of one endpoint TX port among vanilla cores, with
// per-core outstanding-load caps and response steering by reg_id core bits.
module vanilla_multicore_tx_arbiter #(
    parameter int num_cores_p     = 4,
    parameter int payload_width_p = 32,
    parameter int data_width_p    = 32,
    parameter int reg_id_width_p  = 5,
    parameter int max_out_p       = 8
) (
    input logic clk_i,
    input logic reset_n_i,
    vanilla_multicore_tx_arbiter_if.slave bus
);
    localparam int CIW = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;
    localparam int LIW = reg_id_width_p - CIW;
    localparam int CW  = $clog2(max_out_p + 1);

    localparam logic [CW-1:0]  max_c       = CW'(max_out_p);
    localparam logic [CIW:0]   ncores_c    = (CIW+1)'(num_cores_p);
    localparam logic [CIW-1:0] last_core_c = CIW'(num_cores_p - 1);

    logic [CW-1:0]              cnt_q [num_cores_p];
    logic [CW-1:0]              cnt_d [num_cores_p];
    logic [CIW-1:0]             last_q, last_d;
    logic                       err_q, err_d;

    logic [num_cores_p-1:0]     elig;
    logic [CIW:0]               rr_idx;
    logic [CIW-1:0]             win;
    logic                       any_elig;
    logic                       fire;
    logic [payload_width_p-1:0] win_pay;
    logic [LIW-1:0]             win_lid;
    logic                       win_load;

    logic [CIW-1:0]             tgt;
    logic                       tgt_bad;
    logic                       tgt_yumi;
    logic                       ret_take;
    logic [data_width_p-1:0]    ret_data;
    logic [num_cores_p-1:0]     inc;
    logic [num_cores_p-1:0]     dec;

    // A core may request unless it is a load and its counter is at the cap
    always_comb begin
        for (int c = 0; c < num_cores_p; c++) begin
            elig[c] = bus.req_v_i[c]
                    & (~bus.req_load_i[c] | (cnt_q[c] < max_c));
        end
    end

    // Round-robin search starting just after the last granted core
    always_comb begin
        win      = '0;
        any_elig = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= num_cores_p; k++) begin
            rr_idx = {1'b0, last_q} + (CIW+1)'(k);
            if (rr_idx >= ncores_c) begin
                rr_idx = rr_idx - ncores_c;
            end
            if (!any_elig && elig[rr_idx[CIW-1:0]]) begin
                any_elig = 1'b1;
                win      = rr_idx[CIW-1:0];
            end
        end
    end

    // Select the winner's payload, local reg_id and load flag
    always_comb begin
        win_pay  = '0;
        win_lid  = '0;
        win_load = 1'b0;
        for (int c = 0; c < num_cores_p; c++) begin
            if (win == CIW'(c)) begin
                win_pay  = bus.req_payload_i[c*payload_width_p +: payload_width_p];
                win_lid  = bus.req_reg_id_i[c*LIW +: LIW];
                win_load = bus.req_load_i[c];
            end
        end
    end

    assign fire              = reset_n_i & any_elig & bus.out_credit_or_ready_i;
    assign bus.out_v_o       = fire;
    assign bus.out_payload_o = win_pay;
    assign bus.out_reg_id_o  = {win, win_lid};

    // One-hot grant back to the winning core
    always_comb begin
        for (int c = 0; c < num_cores_p; c++) begin
            bus.req_ready_o[c] = fire & (win == CIW'(c));
        end
    end

    // Decode the response target; unknown core IDs are swallowed
    always_comb begin
        tgt      = (num_cores_p == 1) ? '0
                 : bus.returned_reg_id_i[reg_id_width_p-1 -: CIW];
        tgt_bad  = ({1'b0, tgt} >= ncores_c);
        tgt_yumi = 1'b0;
        for (int c = 0; c < num_cores_p; c++) begin
            bus.resp_v_o[c] = reset_n_i & bus.returned_v_i & ~tgt_bad
                            & (tgt == CIW'(c));
            if (tgt == CIW'(c)) begin
                tgt_yumi = bus.resp_yumi_i[c];
            end
        end
    end

    assign ret_take            = reset_n_i & bus.returned_v_i & (tgt_bad | tgt_yumi);
    assign bus.returned_yumi_o = ret_take;
    assign ret_data            = bus.returned_data_i;
    assign bus.resp_data_o     = ret_data;
    assign bus.resp_reg_id_o   = bus.returned_reg_id_i[LIW-1:0];

    // Per-core increment on load issue, decrement on consumed return
    always_comb begin
        for (int c = 0; c < num_cores_p; c++) begin
            inc[c] = fire & win_load & (win == CIW'(c));
            dec[c] = ret_take & ~tgt_bad & (tgt == CIW'(c));
        end
    end

    // Next counter values and protocol-error detection
    always_comb begin
        err_d  = ret_take & tgt_bad;
        last_d = fire ? win : last_q;
        for (int c = 0; c < num_cores_p; c++) begin
            cnt_d[c] = cnt_q[c];
            if (dec[c] && (cnt_q[c] == '0)) begin
                err_d = 1'b1;
            end
            if (inc[c] && !dec[c]) begin
                if (cnt_q[c] == max_c) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end else if (dec[c] && !inc[c] && (cnt_q[c] != '0)) begin
                cnt_d[c] = cnt_q[c] - 1'b1;
            end
        end
    end

    // Expose the counters as a flat vector
    always_comb begin
        for (int c = 0; c < num_cores_p; c++) begin
            bus.outstanding_o[c*CW +: CW] = cnt_q[c];
        end
    end

    assign bus.err_o = err_q;

    // State registers; reset points last_q at the top core so core 0 wins first
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_q <= last_core_c;
            err_q  <= 1'b0;
            for (int c = 0; c < num_cores_p; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            last_q <= last_d;
            err_q  <= err_d;
            for (int c = 0; c < num_cores_p; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end
endmodule
